// File: rtl/clock_sequencer.sv
// rtl/clock_sequencer.sv - CPU clock mode controller: tick divider, button debounce, run/step/burst/halt sequencing
module clock_sequencer #(
  parameter logic [31:0] DIVISOR  = 32'h00FFFFFF,
  parameter logic [15:0] DEBOUNCE = 16'd50000,
  parameter int          CNT_W    = 16
) (
  input  logic             i_SYS_CLOCK,
  input  logic             i_RESET,
  input  logic             i_HALT,
  input  logic             i_STEP_TOGGLE,
  input  logic             i_STEP_CLOCK,
  input  logic             i_BURST_START,
  input  logic [CNT_W-1:0] i_BURST_COUNT,
  output logic             o_TICK,
  output logic [1:0]       o_MODE,
  output logic [CNT_W-1:0] o_REMAINING
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STEP   = 2'd1,
    BURST  = 2'd2,
    HALTED = 2'd3
  } mode_t;

  // Button lane 0 is the run/step toggle, lane 1 is the step button.
  logic [1:0]       btn_raw;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       lvl_q, lvl_d;
  logic [1:0]       ev_q, ev_d;
  logic [1:0][15:0] cnt_q, cnt_d;
  logic             ev_toggle, ev_step;

  mode_t            state_q, state_d;
  logic [31:0]      div_q, div_d, div_next;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             tick_q, tick_d;
  logic             div_wrap, burst_ok, last_tick;

  assign btn_raw   = {i_STEP_CLOCK, i_STEP_TOGGLE};
  assign ev_toggle = ev_q[0];
  assign ev_step   = ev_q[1];

  // Debounce: count consecutive synchronized samples that disagree with the
  // accepted level; accept after DEBOUNCE of them and flag a rising event.
  always_comb begin
    lvl_d = lvl_q;
    ev_d  = '0;
    cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == DEBOUNCE - 16'd1) begin
          lvl_d[i] = sync2_q[i];
          ev_d[i]  = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // Button synchronizers, accepted levels, stable counters and event pulses.
  always_ff @(posedge i_SYS_CLOCK or posedge i_RESET) begin
    if (i_RESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      cnt_q   <= '0;
      ev_q    <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      ev_q    <= ev_d;
    end
  end

  // Divider wrap is only reachable in RUN/BURST; elsewhere the count sits at 0.
  assign div_wrap  = (div_q == DIVISOR - 32'd1);
  assign div_next  = div_wrap ? 32'd0 : div_q + 32'd1;
  assign burst_ok  = i_BURST_START && (i_BURST_COUNT != '0);
  assign last_tick = div_wrap && (rem_q == CNT_W'(1));

  // Mode register plus the registered tick, burst counter and divider.
  always_ff @(posedge i_SYS_CLOCK or posedge i_RESET) begin
    if (i_RESET) begin
      state_q <= RUN;
      div_q   <= '0;
      rem_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      tick_q  <= tick_d;
    end
  end

  // Next mode: halt overrides everything, then toggle, then burst handling.
  always_comb begin
    state_d = state_q;
    if (i_HALT) begin
      state_d = HALTED;
    end else begin
      case (state_q)
        RUN:     if (ev_toggle) state_d = STEP;
        STEP: begin
          if (ev_toggle)     state_d = RUN;
          else if (burst_ok) state_d = BURST;
        end
        BURST:   if (ev_toggle || last_tick) state_d = STEP;
        default: state_d = HALTED;
      endcase
    end
  end

  // Tick, remaining count and divider; the divider restarts on every mode change.
  always_comb begin
    tick_d = 1'b0;
    rem_d  = rem_q;
    div_d  = '0;
    if (!i_HALT) begin
      case (state_q)
        RUN: begin
          if (!ev_toggle) begin
            div_d  = div_next;
            tick_d = div_wrap;
          end
        end
        STEP: begin
          if (!ev_toggle) begin
            if (burst_ok) rem_d  = i_BURST_COUNT;
            else          tick_d = ev_step;
          end
        end
        BURST: begin
          if (ev_toggle) begin
            rem_d = '0;
          end else begin
            div_d = div_next;
            if (div_wrap) begin
              tick_d = 1'b1;
              rem_d  = rem_q - CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_TICK      = tick_q;
  assign o_MODE      = state_q;
  assign o_REMAINING = rem_q;

endmodule

// File: tb/tb_clock_sequencer.sv
// tb/tb_clock_sequencer.sv - self-checking bench for clock_sequencer with a cycle-time reference model
module tb_clock_sequencer;

  localparam logic [31:0] DIV  = 32'd4;
  localparam logic [15:0] DEB  = 16'd3;
  localparam int          CW   = 8;
  localparam int          DIVI = 4;
  localparam int          DEBI = 3;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic          halt = 1'b0;
  logic          tog  = 1'b0;
  logic          stp  = 1'b0;
  logic          bs   = 1'b0;
  logic [CW-1:0] bcnt = '0;
  logic          tick;
  logic [1:0]    mode;
  logic [CW-1:0] rem;

  clock_sequencer #(.DIVISOR(DIV), .DEBOUNCE(DEB), .CNT_W(CW)) dut (
    .i_SYS_CLOCK   (clk),
    .i_RESET       (rst),
    .i_HALT        (halt),
    .i_STEP_TOGGLE (tog),
    .i_STEP_CLOCK  (stp),
    .i_BURST_START (bs),
    .i_BURST_COUNT (bcnt),
    .o_TICK        (tick),
    .o_MODE        (mode),
    .o_REMAINING   (rem)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int tick_seen = 0;

  // Reference model state: absolute edge count since reset and the edge of the next due tick.
  int cyc, m_mode, m_rem, m_next, run_t, run_s;
  bit m_tick, acc_t, acc_s, evp_t, evp_s;
  bit hist_t [0:4095];
  bit hist_s [0:4095];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void deb(input bit s, inout bit acc, inout int run, output bit ev);
    ev = 1'b0;
    if (s != acc) begin
      run++;
      if (run == DEBI) begin
        acc = s;
        run = 0;
        ev  = s;
      end
    end else begin
      run = 0;
    end
  endfunction

  task automatic model_reset();
    cyc = 0; m_mode = 0; m_rem = 0; m_tick = 1'b0; m_next = DIVI;
    acc_t = 1'b0; acc_s = 1'b0; run_t = 0; run_s = 0; evp_t = 1'b0; evp_s = 1'b0;
  endtask

  task automatic model_step();
    bit dtick, st, ss, nt, ns;
    int p;
    cyc++;
    dtick  = (m_mode == 0 || m_mode == 2) && (cyc == m_next);
    m_tick = 1'b0;
    if (halt) begin
      m_mode = 3;
    end else begin
      case (m_mode)
        0: begin
          if (evp_t) m_mode = 1;
          else if (dtick) begin m_tick = 1'b1; m_next += DIVI; end
        end
        1: begin
          if (evp_t) begin m_mode = 0; m_next = cyc + DIVI; end
          else if (bs && bcnt != 0) begin m_mode = 2; m_rem = int'(bcnt); m_next = cyc + DIVI; end
          else if (evp_s) m_tick = 1'b1;
        end
        2: begin
          if (evp_t) begin m_mode = 1; m_rem = 0; end
          else if (dtick) begin
            m_tick = 1'b1;
            m_rem--;
            m_next += DIVI;
            if (m_rem == 0) m_mode = 1;
          end
        end
        default: ;
      endcase
    end
    hist_t[cyc[11:0]] = tog;
    hist_s[cyc[11:0]] = stp;
    p  = cyc - 2;
    st = (cyc >= 3) ? hist_t[p[11:0]] : 1'b0;
    ss = (cyc >= 3) ? hist_s[p[11:0]] : 1'b0;
    deb(st, acc_t, run_t, nt);
    deb(ss, acc_s, run_s, ns);
    evp_t = nt;
    evp_s = ns;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tick) tick_seen++;
        check("cyc_tick", int'(tick), int'(m_tick));
        check("cyc_mode", int'(mode), m_mode);
        check("cyc_rem",  int'(rem),  m_rem);
      end
    end
  end

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int t0;
    cyc_n(2);
    check("reset_tick", int'(tick), 0);
    check("reset_mode", int'(mode), 0);
    check("reset_rem",  int'(rem),  0);
    rst = 1'b0;

    for (int k = 1; k <= 13; k++) begin
      cyc_n(1);
      check("run_tick", int'(tick), (k % 4 == 0) ? 1 : 0);
      check("run_mode", int'(mode), 0);
    end

    tog = 1'b1;
    cyc_n(5); check("toggle_early", int'(mode), 0);
    cyc_n(1); check("toggle_mode",  int'(mode), 1);
    cyc_n(4); tog = 1'b0; cyc_n(8);

    t0  = tick_seen;
    stp = 1'b1;
    cyc_n(5); check("step_early",  int'(tick), 0);
    cyc_n(1); check("step_tick",   int'(tick), 1);
    cyc_n(1); check("step_single", int'(tick), 0);
    cyc_n(3); stp = 1'b0; cyc_n(8);
    check("step_count", tick_seen - t0, 1);

    t0 = tick_seen;
    for (int r = 0; r < 5; r++) begin
      stp = 1'b1; cyc_n(2);
      stp = 1'b0; cyc_n(2);
    end
    cyc_n(10);
    check("reject_ticks", tick_seen - t0, 0);
    check("reject_mode",  int'(mode), 1);

    bs = 1'b1; bcnt = 8'd3; cyc_n(1); bs = 1'b0; bcnt = '0;
    check("burst_mode", int'(mode), 2);
    check("burst_rem",  int'(rem),  3);
    for (int k = 1; k <= 3; k++) begin
      cyc_n(3); check("burst_gap",    int'(tick), 0);
      cyc_n(1); check("burst_tick",   int'(tick), 1);
      check("burst_rem_k",  int'(rem),  3 - k);
      check("burst_mode_k", int'(mode), (k == 3) ? 1 : 2);
    end

    bs = 1'b1; bcnt = 8'd0; cyc_n(1); bs = 1'b0;
    check("burst_zero", int'(mode), 1);
    cyc_n(4); check("burst_zero_hold", int'(mode), 1);

    bs = 1'b1; bcnt = 8'd5; cyc_n(1); bs = 1'b0; bcnt = '0; tog = 1'b1;
    check("abort_start", int'(rem), 5);
    cyc_n(5);
    check("abort_pre_mode", int'(mode), 2);
    check("abort_pre_rem",  int'(rem),  4);
    cyc_n(1);
    check("abort_mode", int'(mode), 1);
    check("abort_rem",  int'(rem),  0);
    cyc_n(4); tog = 1'b0; cyc_n(8);

    bs = 1'b1; bcnt = 8'd5; cyc_n(1); bs = 1'b0; bcnt = '0;
    check("halt_burst", int'(mode), 2);
    cyc_n(3); halt = 1'b1; cyc_n(1); halt = 1'b0;
    check("halt_tick", int'(tick), 0);
    check("halt_mode", int'(mode), 3);
    check("halt_rem",  int'(rem),  5);

    t0 = tick_seen;
    for (int r = 0; r < 10; r++) begin
      tog = 1'b1; stp = 1'b1; bs = 1'b1; bcnt = 8'd2; cyc_n(5);
      tog = 1'b0; stp = 1'b0; bs = 1'b0; bcnt = '0;   cyc_n(5);
    end
    check("halted_ticks", tick_seen - t0, 0);
    check("halted_mode",  int'(mode), 3);
    check("halted_rem",   int'(rem),  5);

    #2 rst = 1'b1;
    #1;
    check("arst_mode", int'(mode), 0);
    check("arst_rem",  int'(rem),  0);
    check("arst_tick", int'(tick), 0);
    cyc_n(1);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cyc_n(1);
      check("arst_run_tick", int'(tick), (k == 4) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_sequencer.md
# clock_sequencer

Mode controller for the CPU clock. It divides `i_SYS_CLOCK` into single-cycle tick enables and sequences four modes: free-run, manual step, counted burst and halted. It debounces the front-panel step and toggle buttons itself. It sits between the board buttons and the CPU core, which advances one instruction phase per `o_TICK`.

## Interface
- `DIVISOR`, 32'h00FFFFFF, `i_SYS_CLOCK` cycles per tick in RUN and BURST; legal range ≥ 2.
- `DEBOUNCE`, 16'd50000, consecutive stable samples required before a button level is accepted; legal range ≥ 1.
- `CNT_W`, 16, width of the burst counter.
- `i_SYS_CLOCK`, in, 1, the only clock; all logic is on its rising edge.
- `i_RESET`, in, 1. Reset is asynchronous and active-high. It forces every register to its reset value immediately.
- `i_HALT`, in, 1, synchronous halt request from the CPU (HLT instruction).
- `i_STEP_TOGGLE`, in, 1, raw asynchronous button that toggles between RUN and STEP.
- `i_STEP_CLOCK`, in, 1, raw asynchronous button; one press produces one tick in STEP.
- `i_BURST_START`, in, 1, synchronous one-cycle request to start a burst.
- `i_BURST_COUNT`, in, CNT_W, number of ticks in the burst; sampled on `i_BURST_START`.
- `o_TICK`, out, 1, registered one-cycle CPU clock enable.
- `o_MODE`, out, 2, current mode: 0 RUN, 1 STEP, 2 BURST, 3 HALTED.
- `o_REMAINING`, out, CNT_W, ticks still owed in the current burst.

## Operation
- **Button inputs.** Each button passes through a 2-flop synchronizer, then a debouncer.
  - The debouncer accepts a new level only after DEBOUNCE consecutive identical synchronized samples that differ from the current accepted level.
  - A 0→1 change of the accepted level produces one internal event pulse: `ev_toggle` or `ev_step`.
- **Divider.** The counter runs 0..DIVISOR-1 only in RUN and BURST.
  - A wrap (count == DIVISOR-1) is a divider tick.
  - The counter is cleared to 0 in STEP and HALTED and on every mode entry.
- **States and transitions.** Priority is applied top-down each cycle.
  - Any state, `i_HALT`=1 → HALTED. HALTED is left only by `i_RESET`.
  - RUN: `ev_toggle` → STEP. Otherwise each divider tick asserts `o_TICK`. `i_BURST_START` and `ev_step` are ignored.
  - STEP: `ev_toggle` → RUN, and any same-cycle `ev_step` or burst start is discarded.
  - STEP: otherwise, `i_BURST_START` with `i_BURST_COUNT` ≠ 0 → BURST, and `o_REMAINING` ← `i_BURST_COUNT`; a same-cycle `ev_step` is discarded.
  - STEP: a count of 0 is ignored, and the block stays in STEP.
  - STEP: otherwise, `ev_step` asserts `o_TICK`.
  - BURST: `ev_toggle` → STEP, `o_REMAINING` ← 0, and no tick is issued that cycle.
  - BURST: otherwise, each divider tick asserts `o_TICK` and decrements `o_REMAINING`. The tick that brings it to 0 is the last; the state → STEP on that same edge.
  - BURST: `i_BURST_START` during BURST is ignored.
- **Arithmetic.** The burst decrement never underflows, because BURST is never entered with 0. The divider counter is 32-bit unsigned.
- **Output rules.**
  - `o_TICK` is never high for 2 consecutive cycles. DIVISOR ≥ 2 guarantees this, and step events are separated by debounce.
  - `o_TICK` is never high in HALTED.

## Timing
- **Reset values.** `o_TICK`=0, `o_MODE`=0 (RUN), `o_REMAINING`=0, divider counter=0, synchronizers=0, debouncers=0 (accepted level 0, stable count 0).
- **RUN cadence.**
  - First `o_TICK` is DIVISOR cycles after reset release or RUN entry.
  - After that, `o_TICK` is high for 1 cycle every DIVISOR cycles.
- **Button latency.** From a raw button rising edge to the event pulse: 2 cycles (sync) + DEBOUNCE cycles.
  - `o_TICK` (STEP) or the `o_MODE` change (toggle) is registered 1 cycle after the event.
- **Burst.**
  - `i_BURST_START` at edge n gives `o_MODE`=2 and `o_REMAINING`=count after edge n.
  - Tick k (k=1..count) occurs k·DIVISOR cycles later.
  - The final tick and `o_MODE`=1 become visible together.
- **Halt.**
  - `i_HALT` sampled high at edge n gives `o_MODE`=3 and `o_TICK`=0 after edge n, even if a divider tick would have fired at n.
  - `o_REMAINING` holds its value.
- **Reset mid-operation.** Asserting `i_RESET` during BURST or HALTED immediately returns to RUN with `o_REMAINING`=0. No tick is pending after reset release.

## Test plan
Bench parameters: DIVISOR=4, DEBOUNCE=3, CNT_W=8.
- **Free run.** Release reset at cycle 0, all inputs low. → `o_TICK` high exactly at cycles 4, 8, 12 and nowhere else; `o_MODE`=0.
- **Toggle and step.**
  - Press toggle cleanly. → `o_MODE`=1 exactly 6 cycles after the edge (2 sync + 3 debounce + 1); no ticks afterward.
  - Then press step. → exactly one `o_TICK`, 6 cycles after the press.
- **Debounce reject.** In STEP, drive step as 0→1 for 2 cycles, 0 for 2 cycles, repeated 5 times, then hold low. → no `o_TICK`, `o_MODE` stays 1.
- **Burst.**
  - In STEP, pulse `i_BURST_START` with count=3. → `o_MODE`=2, `o_REMAINING`=3, then ticks at +4/+8/+12 cycles.
  - `o_REMAINING` reads 2, 1, 0 at those ticks; `o_MODE`=1 with the third tick.
  - Repeat with count=0. → `o_MODE` stays 1.
- **Burst abort and priority.**
  - During a count=5 burst, press toggle. → `o_MODE`=1 and `o_REMAINING`=0 on the event edge.
  - Raise `i_HALT` in the same cycle as a divider tick. → no tick; `o_MODE`=3.
- **Halt and reset.**
  - In HALTED, toggle, step and burst inputs have no effect for 100 cycles.
  - Assert `i_RESET` asynchronously mid-cycle. → outputs immediately read RUN/0/0; the first tick comes 4 cycles after release.
